// File: rtl/windowed_register_file.sv
// windowed_register_file: SPARC-style windowed register file with 8 globals,
// overlapping 16-register windows, CWP/WIM control and write-through bypass.
module windowed_register_file #(
  parameter int WIDTH    = 32,
  parameter int NWINDOWS = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [4:0]                  i_ra,
  input  logic [4:0]                  i_rb,
  input  logic [4:0]                  i_rd,
  output logic [WIDTH-1:0]            o_pa,
  output logic [WIDTH-1:0]            o_pb,
  output logic [WIDTH-1:0]            o_pd,
  input  logic [4:0]                  i_rw,
  input  logic [WIDTH-1:0]            i_pw,
  input  logic                        i_le,
  input  logic                        i_save,
  input  logic                        i_restore,
  input  logic                        i_wim_ld,
  input  logic [NWINDOWS-1:0]         i_wim_in,
  output logic [$clog2(NWINDOWS)-1:0] o_cwp,
  output logic                        o_win_ovf,
  output logic                        o_win_unf
);
  localparam int CW = $clog2(NWINDOWS);
  localparam int NR = 16 * NWINDOWS;
  localparam int IW = CW + 4;

  logic [WIDTH-1:0]    r_glob [8];
  logic [WIDTH-1:0]    r_win  [NR];
  logic [CW-1:0]       r_cwp;
  logic [NWINDOWS-1:0] r_wim;
  logic                r_ovf;
  logic                r_unf;
  logic [IW:0]         w_wmap;
  logic [CW-1:0]       w_dn;
  logic [CW-1:0]       w_up;

  // MSB flags a windowed register; the IW-bit sum wraps mod 16*NWINDOWS
  function automatic logic [IW:0] map(input logic [4:0] r, input logic [CW-1:0] c);
    logic [IW-1:0] s;
    s = {c, 4'b0000} + IW'(r - 5'd8);
    return (r < 5'd8) ? {1'b0, (IW)'(r[2:0])} : {1'b1, s};
  endfunction

  function automatic logic [WIDTH-1:0] rd(input logic [4:0] r);
    logic [IW:0] m;
    m = map(r, r_cwp);
    return (r == 5'd0) ? '0 :
           (i_le && m == w_wmap) ? i_pw :
           m[IW] ? r_win[m[IW-1:0]] : r_glob[m[2:0]];
  endfunction

  assign w_wmap    = map(i_rw, r_cwp);
  assign w_dn      = r_cwp - 1'b1;
  assign w_up      = r_cwp + 1'b1;
  assign o_pa      = rd(i_ra);
  assign o_pb      = rd(i_rb);
  assign o_pd      = rd(i_rd);
  assign o_cwp     = r_cwp;
  assign o_win_ovf = r_ovf;
  assign o_win_unf = r_unf;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 8; i++) r_glob[i] <= '0;
      for (int i = 0; i < NR; i++) r_win[i] <= '0;
      r_cwp <= '0;
      r_wim <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (i_le && i_rw != 5'd0) begin
        if (w_wmap[IW]) r_win[w_wmap[IW-1:0]] <= i_pw;
        else r_glob[w_wmap[2:0]] <= i_pw;
      end
      if (i_wim_ld) r_wim <= i_wim_in;
      r_ovf <= i_save && !i_restore && r_wim[w_dn];
      r_unf <= i_restore && !i_save && r_wim[w_up];
      if (i_save && !i_restore && !r_wim[w_dn]) r_cwp <= w_dn;
      else if (i_restore && !i_save && !r_wim[w_up]) r_cwp <= w_up;
    end
  end
endmodule

// File: tb/tb_windowed_register_file.sv
// tb_windowed_register_file: directed vectors with hand-computed expectations
// for the windowed register file at WIDTH=32, NWINDOWS=4.
module tb_windowed_register_file;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ra = '0, rb = '0, rd = '0, rw = '0;
  logic [31:0] pa, pb, pd;
  logic [31:0] pw = '0;
  logic        le = 1'b0, save = 1'b0, restore = 1'b0, wim_ld = 1'b0;
  logic [3:0]  wim_in = '0;
  logic [1:0]  cwp;
  logic        ovf, unf;
  int          n_pass = 0, n_tot = 0;

  windowed_register_file #(.WIDTH(32), .NWINDOWS(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_ra(ra), .i_rb(rb), .i_rd(rd),
    .o_pa(pa), .o_pb(pb), .o_pd(pd), .i_rw(rw), .i_pw(pw), .i_le(le),
    .i_save(save), .i_restore(restore), .i_wim_ld(wim_ld), .i_wim_in(wim_in),
    .o_cwp(cwp), .o_win_ovf(ovf), .o_win_unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    rw = r; pw = d; le = 1'b1;
    tick();
    le = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_cwp", 32'(cwp), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_unf", 32'(unf), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    // r0 is hardwired to zero
    wr(5'd0, 32'hFFFF_FFFF);
    ra = 5'd0; #1;
    chk("r0_zero", pa, 32'h0);
    // out r8 of window 0 is in r24 of window 3
    wr(5'd8, 32'h0000_00A5);
    save = 1'b1; tick(); save = 1'b0;
    chk("save_cwp3", 32'(cwp), 32'd3);
    chk("save_no_ovf", 32'(ovf), 32'd0);
    rb = 5'd24; #1;
    chk("overlap_r24", pb, 32'h0000_00A5);
    restore = 1'b1; tick(); restore = 1'b0;
    chk("restore_cwp0", 32'(cwp), 32'd0);
    rb = 5'd8; #1;
    chk("back_r8", pb, 32'h0000_00A5);
    // write-through bypass
    rw = 5'd17; ra = 5'd17; rb = 5'd18; pw = 32'h1234_5678; le = 1'b1; #1;
    chk("bypass_same", pa, 32'h1234_5678);
    chk("bypass_other", pb, 32'h0);
    tick(); le = 1'b0; #1;
    chk("after_write", pa, 32'h1234_5678);
    // globals ignore CWP
    wr(5'd3, 32'h55);
    save = 1'b1; tick(); tick(); save = 1'b0;
    chk("two_saves", 32'(cwp), 32'd2);
    rd = 5'd3; #1;
    chk("global_g3", pd, 32'h55);
    save = 1'b1; restore = 1'b1; tick(); save = 1'b0; restore = 1'b0;
    chk("both_cwp", 32'(cwp), 32'd2);
    chk("both_ovf", 32'(ovf), 32'd0);
    chk("both_unf", 32'(unf), 32'd0);
    // in r26 of window 2 is out r10 of window 3
    wr(5'd26, 32'h0000_BEEF);
    restore = 1'b1; tick(); restore = 1'b0;
    chk("cwp3", 32'(cwp), 32'd3);
    rb = 5'd10; #1;
    chk("overlap_r10", pb, 32'h0000_BEEF);
    save = 1'b1; tick(); save = 1'b0;
    // WIM load alongside save checks old WIM
    wim_ld = 1'b1; wim_in = 4'b0001; save = 1'b1; tick(); wim_ld = 1'b0; save = 1'b0;
    chk("wimld_save_cwp", 32'(cwp), 32'd1);
    save = 1'b1; tick(); save = 1'b0;
    chk("ovf_cwp", 32'(cwp), 32'd1);
    chk("ovf_pulse", 32'(ovf), 32'd1);
    chk("ovf_no_unf", 32'(unf), 32'd0);
    tick();
    chk("ovf_clear", 32'(ovf), 32'd0);
    restore = 1'b1; tick(); tick();
    chk("restore_to3", 32'(cwp), 32'd3);
    chk("restore_no_unf", 32'(unf), 32'd0);
    tick(); restore = 1'b0;
    chk("unf_cwp", 32'(cwp), 32'd3);
    chk("unf_pulse", 32'(unf), 32'd1);
    tick();
    chk("unf_clear", 32'(unf), 32'd0);
    // write with save lands in window 3 (idx 49) = r25 of window 2
    rw = 5'd9; pw = 32'h77; le = 1'b1; save = 1'b1; tick(); le = 1'b0; save = 1'b0;
    chk("ws_cwp", 32'(cwp), 32'd2);
    ra = 5'd25; #1;
    chk("ws_target", pa, 32'h77);
    // asynchronous reset mid-cycle
    save = 1'b1; tick(); save = 1'b0;
    chk("pre_rst_cwp", 32'(cwp), 32'd1);
    restore = 1'b1; tick(); restore = 1'b0;
    #2 rst = 1'b1; #1;
    chk("arst_cwp", 32'(cwp), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    chk("arst_unf", 32'(unf), 32'd0);
    ra = 5'd17; rd = 5'd3; rb = 5'd8; #1;
    chk("arst_pa", pa, 32'h0);
    chk("arst_pb", pb, 32'h0);
    chk("arst_pd", pd, 32'h0);
    // requests ignored under reset
    rw = 5'd5; pw = 32'hDEAD; save = 1'b1; wim_ld = 1'b1; wim_in = 4'hF;
    tick(); le = 1'b0; save = 1'b0; wim_ld = 1'b0;
    chk("rst_hold_cwp", 32'(cwp), 32'd0);
    rst = 1'b0;
    ra = 5'd5; #1;
    chk("rst_hold_g5", pa, 32'h0);
    save = 1'b1; tick(); save = 1'b0;
    chk("post_rst_wim", 32'(cwp), 32'd3);
    chk("post_rst_ovf", 32'(ovf), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
